// File: rtl/tile_map_server.sv
// Tile map store for the collision resolver: ROM-driven bulk loader, single-tile write port,
// two combinational pixel-coordinate query ports. Build macro TILE_OOB_SOLID_EN makes off-map queries solid.
module tile_map_server #(
    parameter int TILE_SHIFT = 4,
    parameter int MAP_COLS   = 40,
    parameter int MAP_ROWS   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x1,
    input  logic [9:0]  y1,
    output logic [2:0]  blockType1,
    input  logic [9:0]  x2,
    input  logic [9:0]  y2,
    output logic [2:0]  blockType2,
    input  logic        load_start,
    output logic [10:0] rom_addr,
    input  logic [2:0]  rom_data,
    output logic        busy,
    output logic        load_done,
    output logic        map_valid,
    input  logic        wr_en,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [2:0]  wr_type
);

    localparam int MAP_SIZE = MAP_COLS * MAP_ROWS;
    localparam logic [2:0] SOLID = 3'd1;
`ifdef TILE_OOB_SOLID_EN
    localparam logic [2:0] OOB_TYPE = 3'd1;
`else
    localparam logic [2:0] OOB_TYPE = 3'd0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

    state_t     state, state_next;
    logic [2:0] tiles [0:MAP_SIZE-1];
    logic       load_wr;
    logic       user_wr;
    logic [10:0] load_idx;
    logic [10:0] wr_idx;

    function automatic logic in_map(input logic [9:0] px, input logic [9:0] py);
        return (32'(px >> TILE_SHIFT) < 32'(MAP_COLS)) && (32'(py >> TILE_SHIFT) < 32'(MAP_ROWS));
    endfunction

    function automatic logic [10:0] map_idx(input logic [9:0] px, input logic [9:0] py);
        return 11'(32'(py >> TILE_SHIFT) * 32'(MAP_COLS) + 32'(px >> TILE_SHIFT));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_wr    = 1'b0;
        busy       = (state != IDLE);
        load_done  = (state == FINISH);
        case (state)
            IDLE:    if (load_start) state_next = FETCH;
            FETCH:   state_next = STREAM;
            STREAM: begin
                load_wr = 1'b1;
                if (rom_addr == 11'(MAP_SIZE)) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rom_addr runs one ahead of the tile being written because ROM data lags its address by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            map_valid <= 1'b0;
        end else begin
            if (state == FETCH || state == STREAM) begin
                rom_addr <= rom_addr + 11'd1;
            end else begin
                rom_addr <= '0;
            end
            if (state == FINISH) map_valid <= 1'b1;
        end
    end

    assign load_idx = rom_addr - 11'd1;
    assign wr_idx   = map_idx(wr_x, wr_y);
    assign user_wr  = wr_en && (state == IDLE) && in_map(wr_x, wr_y) && (32'(wr_idx) < 32'(MAP_SIZE));

    always_ff @(posedge clk) begin
        if (load_wr) begin
            tiles[load_idx] <= rom_data;
        end else if (user_wr) begin
            tiles[wr_idx] <= wr_type;
        end
    end

    always_comb begin
        blockType1 = SOLID;
        blockType2 = SOLID;
        if (map_valid && !busy) begin
            blockType1 = in_map(x1, y1) ? tiles[map_idx(x1, y1)] : OOB_TYPE;
            blockType2 = in_map(x2, y2) ? tiles[map_idx(x2, y2)] : OOB_TYPE;
        end
    end

endmodule

// File: tb/tb_tile_map_server.sv
// Directed bench for tile_map_server: reset masking, ROM load timing, queries, off-map handling,
// tile writes, ignored requests during load and reset mid-load.
module tb_tile_map_server;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [2:0]  blockType1, blockType2;
    logic        load_start = 1'b0;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data;
    logic        busy, load_done, map_valid;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_x = '0, wr_y = '0;
    logic [2:0]  wr_type = '0;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TILE_OOB_SOLID_EN
    localparam logic [2:0] OOB_EXP = 3'd1;
`else
    localparam logic [2:0] OOB_EXP = 3'd0;
`endif

    always #5 clk = ~clk;

    // Level ROM image: tile i holds i%4, registered one cycle behind the address
    always @(posedge clk) rom_data <= {1'b0, rom_addr[1:0]};

    tile_map_server dut (
        .clk(clk), .rst(rst),
        .x1(x1), .y1(y1), .blockType1(blockType1),
        .x2(x2), .y2(y2), .blockType2(blockType2),
        .load_start(load_start), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .load_done(load_done), .map_valid(map_valid),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type)
    );

    task automatic test_reset;
        x1 = 10'd100; y1 = 10'd100; x2 = 10'd100; y2 = 10'd100;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %0b expected 0", load_done); end
        n_checks++; if (map_valid !== 1'b0) begin n_fail++; $display("FAIL reset_map_valid: got %0b expected 0", map_valid); end
        n_checks++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL reset_bt1: got %0d expected 1", blockType1); end
        n_checks++; if (blockType2 !== 3'd1) begin n_fail++; $display("FAIL reset_bt2: got %0d expected 1", blockType2); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_autostart: busy got %0b expected 0", busy); end
    endtask

    // Runs one load and checks its timing; inject=1 also issues a write and a second load_start mid-load
    task automatic run_load(input int inject);
        int cyc, busy_cnt, done_cyc, done_cnt;
        x1 = 10'd0; y1 = 10'd0;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        cyc = 1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_rise: got %0b expected 1", busy); end
        n_checks++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL load_rom_addr0: got %0d expected 0", rom_addr); end
        while (busy === 1'b1 && cyc < 1400) begin
            busy_cnt++;
            if (load_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 50) begin
                n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL load_forced_solid: got %0d expected 1", blockType1); end
            end
            if (inject != 0 && cyc == 100) begin
                wr_en = 1'b1; wr_x = 10'd0; wr_y = 10'd0; wr_type = 3'd6; load_start = 1'b1;
            end
            if (inject != 0 && cyc == 101) begin
                wr_en = 1'b0; load_start = 1'b0;
            end
            @(negedge clk); cyc++;
            if (cyc == 2) begin
                n_checks++; if (rom_addr !== 11'd1) begin n_fail++; $display("FAIL load_rom_addr1: got %0d expected 1", rom_addr); end
            end
        end
        n_checks++; if (busy_cnt !== 1202) begin n_fail++; $display("FAIL load_busy_cycles: got %0d expected 1202", busy_cnt); end
        n_checks++; if (done_cyc !== 1202) begin n_fail++; $display("FAIL load_done_cycle: got %0d expected 1202", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL load_done_width: got %0d expected 1", done_cnt); end
        n_checks++; if (cyc !== 1203) begin n_fail++; $display("FAIL load_idle_cycle: got %0d expected 1203", cyc); end
        n_checks++; if (map_valid !== 1'b1) begin n_fail++; $display("FAIL load_map_valid: got %0b expected 1", map_valid); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_clear: got %0b expected 0", load_done); end
    endtask

    task automatic test_map_image(input string tag);
        int bad;
        int idx1, idx2;
        bad = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 40; c++) begin
                x1 = 10'(c * 16 + (c % 16));
                y1 = 10'(r * 16 + 15 - (r % 16));
                x2 = 10'((39 - c) * 16);
                y2 = 10'((29 - r) * 16 + 7);
                idx1 = r * 40 + c;
                idx2 = (29 - r) * 40 + (39 - c);
                #1;
                if (blockType1 !== 3'(idx1 % 4)) bad++;
                if (blockType2 !== 3'(idx2 % 4)) bad++;
            end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL map_image_%s: %0d tiles differ, expected 0", tag, bad); end
    endtask

    task automatic test_load;
        run_load(0);
        x1 = 10'd16; y1 = 10'd0; x2 = 10'd639; y2 = 10'd479;
        #1;
        n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL query_16_0: got %0d expected 1", blockType1); end
        n_checks++; if (blockType2 !== 3'd3) begin n_fail++; $display("FAIL query_639_479: got %0d expected 3", blockType2); end
        x1 = 10'd100; y1 = 10'd100; x2 = 10'd100; y2 = 10'd100;
        #1;
        n_checks++; if (blockType1 !== 3'd2) begin n_fail++; $display("FAIL query_same_tile_p1: got %0d expected 2", blockType1); end
        n_checks++; if (blockType2 !== 3'd2) begin n_fail++; $display("FAIL query_same_tile_p2: got %0d expected 2", blockType2); end
        test_map_image("first");
    endtask

    task automatic test_oob;
        x1 = 10'd640; y1 = 10'd0; x2 = 10'd5; y2 = 10'd1020;
        #1;
        n_checks++; if (blockType1 !== OOB_EXP) begin n_fail++; $display("FAIL oob_640_0: got %0d expected %0d", blockType1, OOB_EXP); end
        n_checks++; if (blockType2 !== OOB_EXP) begin n_fail++; $display("FAIL oob_5_1020: got %0d expected %0d", blockType2, OOB_EXP); end
        x1 = 10'd1023; y1 = 10'd1023; x2 = 10'd639; y2 = 10'd0;
        #1;
        n_checks++; if (blockType1 !== OOB_EXP) begin n_fail++; $display("FAIL oob_1023_1023: got %0d expected %0d", blockType1, OOB_EXP); end
        n_checks++; if (blockType2 !== 3'd3) begin n_fail++; $display("FAIL edge_639_0: got %0d expected 3", blockType2); end
        x1 = 10'd0; y1 = 10'd480;
        #1;
        n_checks++; if (blockType1 !== OOB_EXP) begin n_fail++; $display("FAIL oob_0_480: got %0d expected %0d", blockType1, OOB_EXP); end
    endtask

    task automatic test_write;
        @(negedge clk);
        x2 = 10'd32; y2 = 10'd16;
        wr_en = 1'b1; wr_x = 10'd35; wr_y = 10'd20; wr_type = 3'd0;
        #1;
        n_checks++; if (blockType2 !== 3'd2) begin n_fail++; $display("FAIL write_same_cycle_old: got %0d expected 2", blockType2); end
        @(negedge clk);
        wr_en = 1'b0; x1 = 10'd35; y1 = 10'd20;
        #1;
        n_checks++; if (blockType2 !== 3'd0) begin n_fail++; $display("FAIL write_next_cycle_p2: got %0d expected 0", blockType2); end
        n_checks++; if (blockType1 !== 3'd0) begin n_fail++; $display("FAIL write_next_cycle_p1: got %0d expected 0", blockType1); end
        @(negedge clk);
        x1 = 10'd600; y1 = 10'd300;
        wr_en = 1'b1; wr_x = 10'd600; wr_y = 10'd300; wr_type = 3'd7;
        #1;
        n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL write_reserved_old: got %0d expected 1", blockType1); end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        n_checks++; if (blockType1 !== 3'd7) begin n_fail++; $display("FAIL write_reserved_new: got %0d expected 7", blockType1); end
        @(negedge clk);
        wr_en = 1'b1; wr_x = 10'd639; wr_y = 10'd479; wr_type = 3'd4;
        @(negedge clk);
        wr_en = 1'b0; x2 = 10'd639; y2 = 10'd479;
        #1;
        n_checks++; if (blockType2 !== 3'd4) begin n_fail++; $display("FAIL write_last_tile: got %0d expected 4", blockType2); end
        @(negedge clk);
        wr_en = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_type = 3'd5;
        @(negedge clk);
        wr_en = 1'b0; x1 = 10'd0; y1 = 10'd16;
        #1;
        n_checks++; if (blockType1 !== 3'd0) begin n_fail++; $display("FAIL write_oob_ignored: got %0d expected 0", blockType1); end
    endtask

    task automatic test_load_ignores;
        run_load(1);
        x1 = 10'd0; y1 = 10'd0; x2 = 10'd32; y2 = 10'd16;
        #1;
        n_checks++; if (blockType1 !== 3'd0) begin n_fail++; $display("FAIL ignore_write_tile0: got %0d expected 0", blockType1); end
        n_checks++; if (blockType2 !== 3'd2) begin n_fail++; $display("FAIL reload_restores_tile42: got %0d expected 2", blockType2); end
        test_map_image("reload");
    endtask

    task automatic test_reset_during_load;
        int cyc;
        x1 = 10'd0; y1 = 10'd0; x2 = 10'd32; y2 = 10'd16;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        cyc = 1;
        while (cyc < 600) begin
            @(negedge clk); cyc++;
        end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
        n_checks++; if (map_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_map_valid: got %0b expected 0", map_valid); end
        n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL rst_mid_bt1: got %0d expected 1", blockType1); end
        n_checks++; if (blockType2 !== 3'd1) begin n_fail++; $display("FAIL rst_mid_bt2: got %0d expected 1", blockType2); end
        n_checks++; if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL rst_mid_rom_addr: got %0d expected 0", rom_addr); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resume: busy got %0b expected 0", busy); end
        n_checks++; if (blockType1 !== 3'd1) begin n_fail++; $display("FAIL rst_mid_masked: got %0d expected 1", blockType1); end
        run_load(0);
        test_map_image("after_reset");
    endtask

    initial begin
        test_reset;
        test_load;
        test_oob;
        test_write;
        test_load_ignores;
        test_reset_during_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
